gemm_post_sched: RTL and testbench
==================================

GEMM_POST_SCHED -- requirements
Module: gemm_post_sched

Interface
REQ-001 Parameter NUM_REQ, default 2: number of command requesters, 2..4.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in cycles, 2..65535.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester command valid.
REQ-006 req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-007 req_flags  input  8*NUM_REQ  packed flags; requester i occupies bits [8i+7:8i].
REQ-008 req_scale, req_shift  input  8*NUM_REQ each  packed requant scale and shift.
REQ-009 req_dtype  input  NUM_REQ  0=INT8, 1=FP16.
REQ-010 post_cmd_valid  output  1  command to post-processing unit.
REQ-011 post_cmd_ready  input  1  post unit accepts command.
REQ-012 post_flags, post_scale, post_shift  output  8 each; post_dtype  output  1  latched command fields.
REQ-013 post_done  input  1  post unit completion pulse.
REQ-014 req_done  output  NUM_REQ  one-cycle completion pulse to owning requester.
REQ-015 owner  output  2  index of current owner; valid while busy.
REQ-016 busy  output  1  high in any state other than S_IDLE.
REQ-017 done_cnt  output  16  completed-command count; wraps from 0xFFFF to 0.
REQ-018 err_clr  input  1  clears err_timeout.
REQ-019 err_timeout  output  1  sticky watchdog error.

Function
REQ-020 FSM states SHALL be S_IDLE, S_ISSUE, S_RUN and S_ACK.
REQ-021 S_IDLE: round-robin search of req_valid starting at rr_ptr; req_ready SHALL assert combinationally for the first valid index found only.
REQ-022 Accept on req_valid&req_ready: latch that requester's fields and owner, go to S_ISSUE; post_cmd_valid SHALL rise the next cycle.
REQ-023 S_ISSUE: post_cmd_valid=1, fields held stable; on post_cmd_ready go to S_RUN; post_done in S_ISSUE SHALL be ignored.
REQ-024 S_RUN: on post_done go to S_ACK.
REQ-025 S_ACK lasts one cycle: req_done[owner]=1, done_cnt+1, rr_ptr=owner+1 mod NUM_REQ, then S_IDLE.
REQ-026 Minimum accept-to-next-accept spacing SHALL be 4 cycles; req_ready SHALL be 0 outside S_IDLE.
REQ-027 Requesters holding req_valid SHALL be served in strict rotation; no requester waits more than NUM_REQ-1 other commands.
REQ-028 Requester indices >= NUM_REQ SHALL never be granted.
REQ-029 err_clr and a new timeout in the same cycle: set wins.

Reset
REQ-030 On rst_n low, asynchronously: state=S_IDLE, rr_ptr=0, all outputs and latched fields 0, done_cnt=0, err_timeout=0.
REQ-031 Reset mid-command SHALL drop the command without a req_done pulse; the post unit is not aborted by this block.

Configuration
REQ-032 Macro GEMM_POST_SCHED_WDOG_EN defined: 16-bit counter cleared on S_RUN entry; if TIMEOUT_CYCLES cycles elapse in S_RUN without post_done, set err_timeout and go to S_ACK; req_done still pulses and done_cnt still increments.
REQ-033 Macro undefined: no counter, err_timeout tied 0, err_clr ignored, S_RUN waits indefinitely.

Verification
REQ-034 Single request: req0 valid, flags=0x05, scale=0x40, shift=7, post_cmd_ready high, post_done 10 cycles later -> post_cmd_valid one cycle after accept with 0x05/0x40/7, req_done[0] pulses once, done_cnt=1.
REQ-035 Contention: req0 and req1 held continuously for 4 commands -> grants 0,1,0,1 from reset; req_ready never two-hot.
REQ-036 Backpressure: post_cmd_ready low for 5 cycles -> post_cmd_valid and fields stable; post_done during S_ISSUE does not advance the FSM.
REQ-037 Watchdog (macro on, TIMEOUT_CYCLES=16): no post_done -> err_timeout set after 16 cycles in S_RUN, req_done pulses; err_clr clears it. Macro off: FSM stays in S_RUN.
REQ-038 Reset in S_RUN -> all outputs 0 immediately, no req_done pulse; next grant goes to req0.
REQ-039 done_cnt preloaded by 65535 completions -> the next completion reads 0.

Source files
------------

// File: rtl/gemm_post_sched.sv
// Round-robin command scheduler that feeds a GEMM post-processing unit from NUM_REQ requesters.
// Optional watchdog on the S_RUN wait is built when GEMM_POST_SCHED_WDOG_EN is defined.
module gemm_post_sched #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_flags,
   input  logic [8*NUM_REQ-1:0] req_scale,
   input  logic [8*NUM_REQ-1:0] req_shift,
   input  logic [NUM_REQ-1:0]   req_dtype,
   output logic                 post_cmd_valid,
   input  logic                 post_cmd_ready,
   output logic [7:0]           post_flags,
   output logic [7:0]           post_scale,
   output logic [7:0]           post_shift,
   output logic                 post_dtype,
   input  logic                 post_done,
   output logic [NUM_REQ-1:0]   req_done,
   output logic [1:0]           owner,
   output logic                 busy,
   output logic [15:0]          done_cnt,
   input  logic                 err_clr,
   output logic                 err_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_ACK} state_t;

   localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   state_t             state_reg;
   logic [1:0]         rr_ptr_reg;
   logic [1:0]         owner_reg;
   logic               post_cmd_valid_reg;
   logic [7:0]         post_flags_reg;
   logic [7:0]         post_scale_reg;
   logic [7:0]         post_shift_reg;
   logic               post_dtype_reg;
   logic [NUM_REQ-1:0] req_done_reg;
   logic               busy_reg;
   logic [15:0]        done_cnt_reg;
   logic               wdog_expired;

   logic [NUM_REQ-1:0] rot_valid;
   logic               grant_found;
   logic [1:0]         grant_idx;
   logic [2:0]         grant_sum;
   logic [7:0]         sel_flags;
   logic [7:0]         sel_scale;
   logic [7:0]         sel_shift;
   logic               sel_dtype;

   // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
   assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_reg);

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            grant_found = 1'b1;
            grant_sum   = {1'b0, rr_ptr_reg} + 3'(k);
            if (grant_sum >= 3'(NUM_REQ))
               grant_sum = grant_sum - 3'(NUM_REQ);
            grant_idx = grant_sum[1:0];
         end
      end
      sel_flags = '0;
      sel_scale = '0;
      sel_shift = '0;
      sel_dtype = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == 2'(k)) begin
            sel_flags = req_flags[8*k +: 8];
            sel_scale = req_scale[8*k +: 8];
            sel_shift = req_shift[8*k +: 8];
            sel_dtype = req_dtype[k];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == S_IDLE) && grant_found && (grant_idx == 2'(gi));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= S_IDLE;
         rr_ptr_reg         <= '0;
         owner_reg          <= '0;
         post_cmd_valid_reg <= 1'b0;
         post_flags_reg     <= '0;
         post_scale_reg     <= '0;
         post_shift_reg     <= '0;
         post_dtype_reg     <= 1'b0;
         req_done_reg       <= '0;
         busy_reg           <= 1'b0;
         done_cnt_reg       <= '0;
      end else begin
         req_done_reg <= '0;
         case (state_reg)
            S_IDLE: begin
               if (grant_found) begin
                  state_reg          <= S_ISSUE;
                  owner_reg          <= grant_idx;
                  post_flags_reg     <= sel_flags;
                  post_scale_reg     <= sel_scale;
                  post_shift_reg     <= sel_shift;
                  post_dtype_reg     <= sel_dtype;
                  post_cmd_valid_reg <= 1'b1;
                  busy_reg           <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (post_cmd_ready) begin
                  post_cmd_valid_reg <= 1'b0;
                  state_reg          <= S_RUN;
               end
            end
            S_RUN: begin
               if (post_done || wdog_expired) begin
                  state_reg    <= S_ACK;
                  req_done_reg <= NUM_REQ'(1) << owner_reg;
                  done_cnt_reg <= done_cnt_reg + 16'd1;
               end
            end
            S_ACK: begin
               state_reg  <= S_IDLE;
               busy_reg   <= 1'b0;
               rr_ptr_reg <= (owner_reg == 2'(NUM_REQ - 1)) ? 2'd0 : owner_reg + 2'd1;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef GEMM_POST_SCHED_WDOG_EN
   logic [15:0] wdog_cnt_reg;
   logic        err_timeout_reg;

   assign wdog_expired = (state_reg == S_RUN) && (wdog_cnt_reg == WDOG_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt_reg    <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         if (state_reg == S_ISSUE && post_cmd_ready)
            wdog_cnt_reg <= '0;
         else if (state_reg == S_RUN && wdog_cnt_reg != 16'hFFFF)
            wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
         // A fresh timeout outranks a simultaneous clear.
         if (wdog_expired && !post_done)
            err_timeout_reg <= 1'b1;
         else if (err_clr)
            err_timeout_reg <= 1'b0;
      end
   end

   assign err_timeout = err_timeout_reg;
`else
   logic unused_wdog_cfg;

   assign wdog_expired    = 1'b0;
   assign err_timeout     = 1'b0;
   assign unused_wdog_cfg = ^{err_clr, WDOG_LIMIT};
`endif

   assign post_cmd_valid = post_cmd_valid_reg;
   assign post_flags     = post_flags_reg;
   assign post_scale     = post_scale_reg;
   assign post_shift     = post_shift_reg;
   assign post_dtype     = post_dtype_reg;
   assign req_done       = req_done_reg;
   assign owner          = owner_reg;
   assign busy           = busy_reg;
   assign done_cnt       = done_cnt_reg;

endmodule

// File: tb/tb_gemm_post_sched.sv
// Directed bench for gemm_post_sched with a command scoreboard; watchdog steps follow GEMM_POST_SCHED_WDOG_EN.
module tb_gemm_post_sched;

   localparam int N = 2;

   typedef struct packed {
      logic [1:0] own;
      logic       dt;
      logic [7:0] f;
      logic [7:0] s;
      logic [7:0] sh;
   } cmd_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [8*N-1:0] req_flags = '0;
   logic [8*N-1:0] req_scale = '0;
   logic [8*N-1:0] req_shift = '0;
   logic [N-1:0]   req_dtype = '0;
   logic           post_cmd_valid;
   logic           post_cmd_ready = 1'b0;
   logic [7:0]     post_flags;
   logic [7:0]     post_scale;
   logic [7:0]     post_shift;
   logic           post_dtype;
   logic           post_done = 1'b0;
   logic [N-1:0]   req_done;
   logic [1:0]     owner;
   logic           busy;
   logic [15:0]    done_cnt;
   logic           err_clr = 1'b0;
   logic           err_timeout;

   int     n_chk = 0;
   int     n_pass = 0;
   int     done_seen = 0;
   cmd_t   sb[$];
   int     done_log[$];
   logic [15:0] exp_cnt = '0;

   gemm_post_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_flags(req_flags), .req_scale(req_scale), .req_shift(req_shift), .req_dtype(req_dtype),
      .post_cmd_valid(post_cmd_valid), .post_cmd_ready(post_cmd_ready),
      .post_flags(post_flags), .post_scale(post_scale), .post_shift(post_shift), .post_dtype(post_dtype),
      .post_done(post_done), .req_done(req_done), .owner(owner), .busy(busy),
      .done_cnt(done_cnt), .err_clr(err_clr), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic cmd_t mk(input int o, input logic [7:0] f, input logic [7:0] s,
                               input logic [7:0] sh, input logic dt);
      cmd_t c;
      c.own = 2'(o); c.dt = dt; c.f = f; c.s = s; c.sh = sh;
      return c;
   endfunction

   task automatic set_req(input int i, input logic [7:0] f, input logic [7:0] s,
                          input logic [7:0] sh, input logic dt);
      req_flags[8*i +: 8] = f;
      req_scale[8*i +: 8] = s;
      req_shift[8*i +: 8] = sh;
      req_dtype[i]        = dt;
   endtask

   // One complete command from a single requester; dly = idle RUN cycles before post_done.
   task automatic run_cmd(input int idx, input logic [7:0] f, input logic [7:0] s,
                          input logic [7:0] sh, input logic dt, input int dly);
      logic [N-1:0] onehot;
      onehot = '0;
      onehot[idx] = 1'b1;
      set_req(idx, f, s, sh, dt);
      req_valid = onehot;
      post_cmd_ready = 1'b1;
      sb.push_back(mk(idx, f, s, sh, dt));
      #1;
      chk("grant", 32'(req_ready), 32'(onehot));
      step();
      chk("cmd_valid_latency", 32'(post_cmd_valid), 1);
      chk("owner", 32'(owner), 32'(idx));
      req_valid = '0;
      step();
      chk("run_valid_low", 32'(post_cmd_valid), 0);
      repeat (dly) step();
      post_done = 1'b1;
      step();
      post_done = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("req_done", 32'(req_done), 32'(onehot));
      chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
      step();
      chk("done_pulse_width", 32'(req_done), 0);
      chk("idle_busy", 32'(busy), 0);
   endtask

   // Scoreboard side: pops on each post handshake, logs each completion.
   always @(negedge clk) begin
      if (rst_n) begin
         if (|req_valid)
            chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
         if (post_cmd_valid && post_cmd_ready) begin
            cmd_t e;
            $display("cmd owner=%0d flags=%02h scale=%02h shift=%02h dtype=%0d",
                     owner, post_flags, post_scale, post_shift, post_dtype);
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("cmd_fields", 32'({owner, post_dtype, post_flags, post_scale, post_shift}), 32'(e));
            end
         end
         if (req_done != '0) begin
            done_seen++;
            for (int i = 0; i < N; i++)
               if (req_done[i]) done_log.push_back(i);
            $display("done req_done=%b done_cnt=%0d", req_done, done_cnt);
         end
      end
   end

   initial begin
      int got;
      int start_seen;
      int bound;
      cmd_t held;

      // Reset state
      #3 rst_n = 1'b0;
      #1;
      chk("rst_cmd_valid", 32'(post_cmd_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done_cnt", 32'(done_cnt), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_req_done", 32'(req_done), 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Contention: grants alternate 0,1,0,1 from reset
      set_req(0, 8'h11, 8'h22, 8'h03, 1'b0);
      set_req(1, 8'hA1, 8'hB2, 8'h05, 1'b1);
      sb.push_back(mk(0, 8'h11, 8'h22, 8'h03, 1'b0));
      sb.push_back(mk(1, 8'hA1, 8'hB2, 8'h05, 1'b1));
      sb.push_back(mk(0, 8'h11, 8'h22, 8'h03, 1'b0));
      sb.push_back(mk(1, 8'hA1, 8'hB2, 8'h05, 1'b1));
      req_valid = 2'b11;
      post_cmd_ready = 1'b1;
      post_done = 1'b1;
      start_seen = done_log.size();
      got = 0;
      bound = 0;
      while (got < 4 && bound < 40) begin
         step();
         bound++;
         if (req_done != '0) got++;
      end
      req_valid = '0;
      post_done = 1'b0;
      chk("contention_completions", 32'(got), 4);
      exp_cnt = exp_cnt + 16'd4;
      chk("contention_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      step();
      chk("contention_log_size", 32'(done_log.size() - start_seen), 4);
      for (int i = 0; i < 4; i++)
         if (start_seen + i < done_log.size())
            chk("contention_order", 32'(done_log[start_seen + i]), 32'(i % 2));
      chk("contention_sb_drained", 32'(sb.size()), 0);

      // Single request, post_done roughly 10 cycles after issue
      run_cmd(0, 8'h05, 8'h40, 8'h07, 1'b0, 9);

      // Reset while in S_RUN drops the command; pointer returns to req0
      set_req(1, 8'h66, 8'h77, 8'h02, 1'b1);
      req_valid = 2'b10;
      post_cmd_ready = 1'b1;
      sb.push_back(mk(1, 8'h66, 8'h77, 8'h02, 1'b1));
      #1;
      chk("rr_after_req0", 32'(req_ready), 32'(2'b10));
      step();
      req_valid = '0;
      step();
      chk("pre_reset_busy", 32'(busy), 1);
      start_seen = done_seen;
      #2 rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_flags", 32'(post_flags), 0);
      chk("async_rst_done_cnt", 32'(done_cnt), 0);
      chk("async_rst_owner", 32'(owner), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_no_done_pulse", 32'(done_seen), 32'(start_seen));
      set_req(0, 8'h99, 8'h88, 8'h01, 1'b0);
      req_valid = 2'b11;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'(2'b01));
      req_valid = '0;
      run_cmd(0, 8'h99, 8'h88, 8'h01, 1'b0, 0);

      // Backpressure on req1; early post_done must be ignored in S_ISSUE
      set_req(1, 8'h3C, 8'h7E, 8'h09, 1'b1);
      held = mk(1, 8'h3C, 8'h7E, 8'h09, 1'b1);
      sb.push_back(held);
      req_valid = 2'b10;
      post_cmd_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(req_ready), 32'(2'b10));
      step();
      req_valid = '0;
      set_req(1, 8'h00, 8'hFF, 8'h00, 1'b0);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(post_cmd_valid), 1);
         chk("bp_fields", 32'({owner, post_dtype, post_flags, post_scale, post_shift}), 32'(held));
         chk("bp_no_done", 32'(req_done), 0);
         post_done = (c == 1);
         step();
      end
      post_done = 1'b0;
      chk("bp_still_issue", 32'(post_cmd_valid), 1);
      post_cmd_ready = 1'b1;
      step();
      chk("bp_run_valid_low", 32'(post_cmd_valid), 0);
      step();
      chk("bp_run_waits", 32'(busy), 1);
      chk("bp_run_no_done", 32'(req_done), 0);
      post_done = 1'b1;
      step();
      post_done = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_req_done", 32'(req_done), 32'(2'b10));
      chk("bp_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      step();

      // Watchdog behaviour on req0 with no post_done
      set_req(0, 8'h0F, 8'hF0, 8'h04, 1'b1);
      sb.push_back(mk(0, 8'h0F, 8'hF0, 8'h04, 1'b1));
      req_valid = 2'b01;
      post_cmd_ready = 1'b1;
      step();
      req_valid = '0;
      step();
      start_seen = done_seen;
`ifdef GEMM_POST_SCHED_WDOG_EN
      repeat (15) step();
      chk("wdog_not_yet", 32'(err_timeout), 0);
      chk("wdog_no_done_yet", 32'(req_done), 0);
      step();
      exp_cnt = exp_cnt + 16'd1;
      chk("wdog_err_set", 32'(err_timeout), 1);
      chk("wdog_req_done", 32'(req_done), 32'(2'b01));
      chk("wdog_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      step();
      chk("wdog_err_sticky", 32'(err_timeout), 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("wdog_err_cleared", 32'(err_timeout), 0);
`else
      repeat (40) step();
      chk("nowdog_busy", 32'(busy), 1);
      chk("nowdog_no_done", 32'(done_seen), 32'(start_seen));
      chk("nowdog_err", 32'(err_timeout), 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      post_done = 1'b1;
      step();
      post_done = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      chk("nowdog_req_done", 32'(req_done), 32'(2'b01));
      chk("nowdog_done_cnt", 32'(done_cnt), 32'(exp_cnt));
      step();
`endif

      // Counter wrap: preload to 0xFFFF, the next completion reads 0
      dut.done_cnt_reg = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      run_cmd(1, 8'h5A, 8'hA5, 8'h06, 1'b0, 2);
      chk("wrap_zero", 32'(done_cnt), 0);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1);
   end

endmodule
